board_input_port: RTL

- Memory-mapped input peripheral that carries board switches and push-buttons into the CPU. This is the inbound counterpart to the debug/display path, which carries CPU state out to LEDs/7-segment.
- Synchronizes and debounces the raw board inputs (SW[9:0], active-low KEY[3:0]) and latches edge events.
- Exposes levels and events on the CPU data bus as word registers; optional interrupt output.
- Clocked by the CPU clock; placed beside the data memory on the load/store path.

---
 rtl/board_input_pkg.sv | 12 +
 rtl/board_input_debounce.sv | 29 ++
 rtl/board_input_port.sv | 63 ++++++
 3 files changed

// File: rtl/board_input_pkg.sv
// board_input_pkg: register offsets, input counts and event bit indices shared by board_input_port
package board_input_pkg;
  localparam int NUM_SW = 10;
  localparam int NUM_KEY = 4;
  localparam int NUM_IN = NUM_SW + NUM_KEY;
  localparam logic [3:0] OFF_SW = 4'h0;
  localparam logic [3:0] OFF_KEY = 4'h4;
  localparam logic [3:0] OFF_EVENT = 4'h8;
  localparam logic [3:0] OFF_CTRL = 4'hC;
  localparam int EV_KEY0 = 0;
  localparam int EV_SW0 = NUM_KEY;
endpackage

// File: rtl/board_input_debounce.sv
// board_input_debounce: one-bit synchronizer, debounce counter and stable flop with combinational change pulse (clk, rst, din -> stable, change)
module board_input_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable,
  output logic change
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] count;
  logic synced;
  assign synced = sync[SYNC_STAGES-1];
  assign change = (synced != stable) && (count == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      stable <= 1'b0;
      count <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      stable <= change ? synced : stable;
      count <= (synced == stable || change) ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/board_input_port.sv
// board_input_port: debounced SW/KEY input peripheral with SW/KEY/EVENT(W1C)/CTRL word registers; oIrq exists only with BOARD_INPUT_IRQ_EN
module board_input_port
  import board_input_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFF20_0000,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clockCPU,
  input  logic        reset,
  input  logic [9:0]  iSW,
  input  logic [3:0]  iKEY,
  input  logic [31:0] iAddress,
  input  logic        iReadEnable,
  input  logic        iWriteEnable,
  input  logic [31:0] iWriteData,
  output logic [31:0] oReadData
`ifdef BOARD_INPUT_IRQ_EN
  ,
  output logic        oIrq
`endif
);
  logic [NUM_IN-1:0] raw, stable, change, ev, w1c, flags, mask;
  logic hit;
  logic [31:0] rd;
  logic unused_wdata;
  assign raw = {iSW, ~iKEY};
  assign unused_wdata = ^iWriteData[31:NUM_IN];
  for (genvar i = 0; i < NUM_IN; i++) begin : g_db
    board_input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_db (
      .clk(clockCPU),
      .rst(reset),
      .din(raw[i]),
      .stable(stable[i]),
      .change(change[i])
    );
  end
  always_comb begin
    hit = (iAddress[31:4] == BASE_ADDR[31:4]) && (iAddress[1:0] == 2'b00);
    ev = {change[NUM_IN-1:EV_SW0], change[EV_SW0-1:EV_KEY0] & ~stable[EV_SW0-1:EV_KEY0]};
    w1c = (iWriteEnable && hit && iAddress[3:0] == OFF_EVENT) ? iWriteData[NUM_IN-1:0] : '0;
    rd = (iAddress[3:0] == OFF_SW) ? 32'(stable[NUM_IN-1:EV_SW0]) :
         (iAddress[3:0] == OFF_KEY) ? 32'(stable[EV_SW0-1:EV_KEY0]) :
         (iAddress[3:0] == OFF_EVENT) ? 32'(flags) : 32'(mask);
  end
  always_ff @(posedge clockCPU) begin
    if (reset) begin
      flags <= '0;
      mask <= '0;
      oReadData <= '0;
    end else begin
      flags <= (flags & ~w1c) | ev;
      mask <= (iWriteEnable && hit && iAddress[3:0] == OFF_CTRL) ? iWriteData[NUM_IN-1:0] : mask;
      oReadData <= (iReadEnable && hit) ? rd : '0;
    end
  end
`ifdef BOARD_INPUT_IRQ_EN
  always_ff @(posedge clockCPU) oIrq <= reset ? 1'b0 : |(flags & mask);
`endif
endmodule
